// File: rtl/regfile_sb.sv
// Single-clock integer register file with NREAD registered-address read ports,
// one write port with same-cycle forwarding, and a per-register busy scoreboard.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   r_enable,
  input  logic [NREAD*AW-1:0]    rs_select,
  output logic [NREAD*WIDTH-1:0] rs_out,
  output logic [NREAD-1:0]       rs_busy,
  input  logic                   w_enable,
  input  logic [AW-1:0]          rd_select,
  input  logic [WIDTH-1:0]       w_val,
  input  logic                   iss_enable,
  input  logic [AW-1:0]          iss_rd
);

  logic [WIDTH-1:0] r_file [DEPTH];
  logic [AW-1:0]    sel_q  [NREAD];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             wr_ok;

  // A write to x0 is dropped entirely when x0 is hardwired, so it must not forward either.
  assign wr_ok = w_enable && !(ZERO_REG && (rd_select == '0));

  always_comb begin
    busy_next = busy;
    if (w_enable) begin
      busy_next[rd_select] = 1'b0;
    end
    // Issue after writeback: the newer producer is still outstanding.
    if (iss_enable) begin
      busy_next[iss_rd] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_next[0] = 1'b0;
    end
  end

  // ---- state update: selects, array, scoreboard ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_file[j] <= '0;
      end
      for (int i = 0; i < NREAD; i++) begin
        sel_q[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (r_enable) begin
        for (int i = 0; i < NREAD; i++) begin
          sel_q[i] <= rs_select[i*AW +: AW];
        end
      end
      if (wr_ok) begin
        r_file[rd_select] <= w_val;
      end
      busy <= busy_next;
    end
  end

  // ---- combinational read with forwarding ----
  always_comb begin
    rs_out  = '0;
    rs_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ZERO_REG && (sel_q[i] == '0)) begin
        rs_out[i*WIDTH +: WIDTH] = '0;
        rs_busy[i]               = 1'b0;
      end else if (wr_ok && (rd_select == sel_q[i])) begin
        // The in-flight write satisfies the read, so it is not reported busy.
        rs_out[i*WIDTH +: WIDTH] = w_val;
        rs_busy[i]               = 1'b0;
      end else begin
        rs_out[i*WIDTH +: WIDTH] = r_file[sel_q[i]];
        rs_busy[i]               = busy[sel_q[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed checks on a default instance plus randomized
// checks of a default and a wide (DEPTH=16, NREAD=4, WIDTH=64, ZERO_REG=0) instance.
module tb_regfile_sb;
  localparam int AW_A = 5, NR_A = 2, W_A = 32;
  localparam int AW_B = 4, NR_B = 4, W_B = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   a_r_en, a_w_en, a_iss_en;
  logic [NR_A*AW_A-1:0]   a_sel;
  logic [NR_A*W_A-1:0]    a_out;
  logic [NR_A-1:0]        a_busy;
  logic [AW_A-1:0]        a_rd, a_iss_rd;
  logic [W_A-1:0]         a_wv;

  logic                   b_r_en, b_w_en, b_iss_en;
  logic [NR_B*AW_B-1:0]   b_sel;
  logic [NR_B*W_B-1:0]    b_out;
  logic [NR_B-1:0]        b_busy;
  logic [AW_B-1:0]        b_rd, b_iss_rd;
  logic [W_B-1:0]         b_wv;

  regfile_sb #(.WIDTH(W_A), .DEPTH(32), .NREAD(NR_A), .ZERO_REG(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .r_enable(a_r_en), .rs_select(a_sel), .rs_out(a_out),
    .rs_busy(a_busy), .w_enable(a_w_en), .rd_select(a_rd), .w_val(a_wv),
    .iss_enable(a_iss_en), .iss_rd(a_iss_rd)
  );

  regfile_sb #(.WIDTH(W_B), .DEPTH(16), .NREAD(NR_B), .ZERO_REG(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .r_enable(b_r_en), .rs_select(b_sel), .rs_out(b_out),
    .rs_busy(b_busy), .w_enable(b_w_en), .rd_select(b_rd), .w_val(b_wv),
    .iss_enable(b_iss_en), .iss_rd(b_iss_rd)
  );

  int total = 0;
  int bad = 0;

  // Reference model: register contents, busy flags and captured selects per instance.
  logic [63:0] mem [2][32];
  bit          bsy [2][32];
  int          selm [2][4];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_r_en = 0; a_w_en = 0; a_iss_en = 0; a_sel = '0; a_rd = '0; a_iss_rd = '0; a_wv = '0;
    b_r_en = 0; b_w_en = 0; b_iss_en = 0; b_sel = '0; b_rd = '0; b_iss_rd = '0; b_wv = '0;
  endtask

  task automatic m_reset();
    for (int u = 0; u < 2; u++) begin
      for (int r = 0; r < 32; r++) begin
        mem[u][r] = '0;
        bsy[u][r] = 1'b0;
      end
      for (int p = 0; p < 4; p++) selm[u][p] = 0;
    end
  endtask

  task automatic get_in(int u, output bit re, output bit we, output bit ie, output int rd,
                        output int ir, output logic [63:0] wv, output logic [15:0] sv,
                        output int nr, output int aw);
    if (u == 0) begin
      re = a_r_en; we = a_w_en; ie = a_iss_en; rd = int'(a_rd); ir = int'(a_iss_rd);
      wv = 64'(a_wv); sv = 16'(a_sel); nr = NR_A; aw = AW_A;
    end else begin
      re = b_r_en; we = b_w_en; ie = b_iss_en; rd = int'(b_rd); ir = int'(b_iss_rd);
      wv = b_wv; sv = b_sel; nr = NR_B; aw = AW_B;
    end
  endtask

  task automatic m_read(int u, int p, output logic [63:0] d, output bit b);
    bit re, we, ie, z, fwd;
    int rd, ir, nr, aw, s;
    logic [63:0] wv;
    logic [15:0] sv;
    get_in(u, re, we, ie, rd, ir, wv, sv, nr, aw);
    z = (u == 0);
    s = selm[u][p];
    fwd = we && !(z && rd == 0) && (rd == s);
    if (z && s == 0) begin
      d = '0; b = 1'b0;
    end else if (fwd) begin
      d = wv; b = 1'b0;
    end else begin
      d = mem[u][s]; b = bsy[u][s];
    end
  endtask

  task automatic m_edge();
    for (int u = 0; u < 2; u++) begin
      bit re, we, ie, z;
      int rd, ir, nr, aw;
      logic [63:0] wv;
      logic [15:0] sv;
      get_in(u, re, we, ie, rd, ir, wv, sv, nr, aw);
      z = (u == 0);
      if (re) begin
        for (int p = 0; p < nr; p++) selm[u][p] = int'((sv >> (p*aw)) & 16'((1 << aw) - 1));
      end
      if (we && !(z && rd == 0)) mem[u][rd] = wv;
      if (we) bsy[u][rd] = 1'b0;
      if (ie) bsy[u][ir] = 1'b1;
      if (z) bsy[u][0] = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] d;
    bit b;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_out", 64'(a_out), 64'h0);
    chk("reset_a_busy", 64'(a_busy), 64'h0);
    chk("reset_b_busy", 64'(b_busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // capture x1/x2 after reset, then write x5 and read it back
    a_r_en = 1; a_sel = {5'd2, 5'd1};
    tick();
    a_r_en = 0;
    #1;
    chk("x1x2_out", 64'(a_out), 64'h0);
    chk("x1x2_busy", 64'(a_busy), 64'h0);
    a_w_en = 1; a_rd = 5'd5; a_wv = 32'hDEADBEEF;
    tick();
    a_w_en = 0; a_r_en = 1; a_sel[4:0] = 5'd5;
    tick();
    a_r_en = 0;
    #1;
    chk("x5_read", 64'(a_out[31:0]), 64'hDEADBEEF);

    // forwarding on port 1
    a_r_en = 1; a_sel[9:5] = 5'd7;
    tick();
    a_r_en = 0; a_w_en = 1; a_rd = 5'd7; a_wv = 32'h1234;
    #1;
    chk("fwd_same_cycle", 64'(a_out[63:32]), 64'h1234);
    tick();
    a_w_en = 0;
    #1;
    chk("fwd_after_edge", 64'(a_out[63:32]), 64'h1234);

    // zero register: hardwired on u_a, ordinary on u_b
    a_w_en = 1; a_rd = 5'd0; a_wv = 32'hFFFFFFFF; a_iss_en = 1; a_iss_rd = 5'd0;
    b_w_en = 1; b_rd = 4'd0; b_wv = 64'hFFFFFFFF; b_iss_en = 1; b_iss_rd = 4'd0;
    tick();
    a_w_en = 0; a_iss_en = 0; b_w_en = 0; b_iss_en = 0;
    a_r_en = 1; a_sel[4:0] = 5'd0; b_r_en = 1; b_sel = '0;
    tick();
    a_r_en = 0; b_r_en = 0;
    #1;
    chk("x0_a_out", 64'(a_out[31:0]), 64'h0);
    chk("x0_a_busy", 64'(a_busy[0]), 64'h0);
    chk("x0_b_out", b_out[63:0], 64'hFFFFFFFF);
    chk("x0_b_out_p3", b_out[255:192], 64'hFFFFFFFF);
    chk("x0_b_busy", 64'(b_busy), 64'hF);

    // scoreboard: issue, writeback, and issue+writeback on the same edge
    a_iss_en = 1; a_iss_rd = 5'd3;
    tick();
    a_iss_en = 0; a_r_en = 1; a_sel[4:0] = 5'd3;
    tick();
    a_r_en = 0;
    #1;
    chk("x3_issued_busy", 64'(a_busy[0]), 64'h1);
    a_w_en = 1; a_rd = 5'd3; a_wv = 32'd9;
    #1;
    chk("x3_wb_busy", 64'(a_busy[0]), 64'h0);
    chk("x3_wb_out", 64'(a_out[31:0]), 64'd9);
    tick();
    a_w_en = 0;
    #1;
    chk("x3_after_wb_busy", 64'(a_busy[0]), 64'h0);
    chk("x3_after_wb_out", 64'(a_out[31:0]), 64'd9);
    a_w_en = 1; a_rd = 5'd3; a_wv = 32'h77; a_iss_en = 1; a_iss_rd = 5'd3;
    #1;
    chk("x3_both_cur_busy", 64'(a_busy[0]), 64'h0);
    chk("x3_both_cur_out", 64'(a_out[31:0]), 64'h77);
    tick();
    a_w_en = 0; a_iss_en = 0;
    #1;
    chk("x3_both_next_busy", 64'(a_busy[0]), 64'h1);
    chk("x3_both_next_out", 64'(a_out[31:0]), 64'h77);

    // asynchronous reset in the middle of operation
    a_w_en = 1; a_rd = 5'd4; a_wv = 32'hA5A5A5A5; a_iss_en = 1; a_iss_rd = 5'd4;
    tick();
    a_w_en = 0; a_iss_en = 0; a_r_en = 1; a_sel[4:0] = 5'd4;
    tick();
    a_r_en = 0;
    #1;
    chk("x4_pre_rst_out", 64'(a_out[31:0]), 64'hA5A5A5A5);
    chk("x4_pre_rst_busy", 64'(a_busy[0]), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("x4_in_rst_out", 64'(a_out), 64'h0);
    chk("x4_in_rst_busy", 64'(a_busy), 64'h0);
    a_w_en = 1; a_rd = 5'd4; a_wv = 32'h1; a_iss_en = 1; a_iss_rd = 5'd4;
    tick();
    a_w_en = 0; a_iss_en = 0;
    rst_n = 1'b1;
    a_r_en = 1; a_sel[4:0] = 5'd4;
    tick();
    a_r_en = 0;
    #1;
    chk("x4_post_rst_out", 64'(a_out[31:0]), 64'h0);
    chk("x4_post_rst_busy", 64'(a_busy[0]), 64'h0);

    // randomized traffic against the reference model
    rst_n = 1'b0;
    idle_inputs();
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 1000; c++) begin
      a_r_en = 1'($urandom); a_w_en = 1'($urandom); a_iss_en = 1'($urandom_range(0, 3) == 0);
      for (int p = 0; p < NR_A; p++) a_sel[p*AW_A +: AW_A] = 5'($urandom_range(0, 7));
      a_rd = 5'($urandom_range(0, 7)); a_iss_rd = 5'($urandom_range(0, 7)); a_wv = $urandom;
      b_r_en = 1'($urandom); b_w_en = 1'($urandom); b_iss_en = 1'($urandom_range(0, 3) == 0);
      b_sel = 16'($urandom);
      b_rd = 4'($urandom); b_iss_rd = 4'($urandom); b_wv = {$urandom, $urandom};
      #1;
      for (int p = 0; p < NR_A; p++) begin
        m_read(0, p, d, b);
        chk("rand_a_data", 64'(a_out[p*W_A +: W_A]), d);
        chk("rand_a_busy", 64'(a_busy[p]), 64'(b));
      end
      for (int p = 0; p < NR_B; p++) begin
        m_read(1, p, d, b);
        chk("rand_b_data", b_out[p*W_B +: W_B], d);
        chk("rand_b_busy", 64'(b_busy[p]), 64'(b));
      end
      m_edge();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
